// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
// Optional perf counters in the top are enabled by MEM_ARB_PERF_EN.
package mem_arb_pkg;

  localparam int ARB_AW       = 15;
  localparam int LAT_DEF      = 2;
  localparam int MAX_WAIT_DEF = 3;

  typedef struct packed {
    logic valid;
    logic is_fetch;
  } rsp_t;

  function automatic rsp_t kill_fetch(rsp_t e, logic flush);
    rsp_t r;
    r = e;
    if (flush && e.is_fetch) r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// LAT-deep tagged response tracker; a flush kills every fetch entry.
// The tail entry names the owner of the read data arriving this cycle.
module mem_rsp_pipe
  import mem_arb_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  rsp_t ent,
  output logic f_rvalid,
  output logic d_rvalid
);

  rsp_t pipe [LAT];
  rsp_t tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= kill_fetch(ent, flush);
      for (int i = 1; i < LAT; i++)
        pipe[i] <= kill_fetch(pipe[i-1], flush);
    end
  end

  assign tail = pipe[LAT-1];

  // The flush cycle itself must not deliver a stale fetch word.
  assign f_rvalid = tail.valid & tail.is_fetch & ~flush;
  assign d_rvalid = tail.valid & ~tail.is_fetch;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data first, fetch protected from starvation.
// Define MEM_ARB_PERF_EN to add the perf_* counter ports.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT      = LAT_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int AW       = ARB_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [15:0]   f_rdata,
  input  logic          d_req,
  input  logic          d_wen,
  input  logic [AW-1:0] d_addr,
  input  logic [15:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [15:0]   d_rdata,
  output logic          m_en,
  output logic          m_wen,
  output logic [AW-1:0] m_addr,
  output logic [15:0]   m_wdata,
  input  logic [15:0]   m_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_f_stall,
  output logic [31:0]   perf_d_gnt,
  output logic [31:0]   perf_starve
`endif
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt;
  logic          starve;
  logic          f_eff;
  rsp_t          ent;

  assign starve = (cnt == CMAX);
  assign f_eff  = f_req & ~flush;

  // Grants are gated by rst_n so nothing leaks out during reset.
  assign d_gnt = rst_n & d_req & ~(starve & f_eff);
  assign f_gnt = rst_n & f_eff & ~d_gnt;

  assign m_en    = f_gnt | d_gnt;
  assign m_wen   = d_gnt & d_wen;
  assign m_addr  = d_gnt ? d_addr : f_addr;
  assign m_wdata = d_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (f_gnt || !f_eff) begin
      cnt <= '0;
    end else if (cnt != CMAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign ent = {f_gnt | (d_gnt & ~d_wen), f_gnt};

  mem_rsp_pipe #(
    .LAT (LAT)
  ) u_rsp (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .ent      (ent),
    .f_rvalid (f_rvalid),
    .d_rvalid (d_rvalid)
  );

  assign f_rdata = m_rdata;
  assign d_rdata = m_rdata;

`ifdef MEM_ARB_PERF_EN
  // A forced grant is a fetch that beat a pending data request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_f_stall <= '0;
      perf_d_gnt   <= '0;
      perf_starve  <= '0;
    end else if (!flush) begin
      if (f_eff && !f_gnt)
        perf_f_stall <= perf_f_stall + 32'd1;
      if (d_gnt)
        perf_d_gnt <= perf_d_gnt + 32'd1;
      if (starve && f_gnt && d_req)
        perf_starve <= perf_starve + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a
// transaction-level model (grant rule, shadow memory, response queue).
module tb_mem_port_arbiter;

  localparam int LAT      = 2;
  localparam int MAX_WAIT = 3;
  localparam int AW       = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_gnt;
  logic          f_rvalid;
  logic [15:0]   f_rdata;
  logic          d_req = 1'b0;
  logic          d_wen = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [15:0]   d_wdata = '0;
  logic          d_gnt;
  logic          d_rvalid;
  logic [15:0]   d_rdata;
  logic          m_en;
  logic          m_wen;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_wdata;
  logic [15:0]   m_rdata;

  mem_port_arbiter #(
    .LAT      (LAT),
    .MAX_WAIT (MAX_WAIT),
    .AW       (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_wen    (d_wen),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_en     (m_en),
    .m_wen    (m_wen),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(logic [AW-1:0] a);
    return 16'h5A00 ^ 16'(a);
  endfunction

  // Memory macro: LAT-cycle read latency, write on m_en & m_wen.
  logic [15:0] mem [1 << AW];
  bit          mem_wr [1 << AW];
  logic [15:0] rd [LAT];

  always @(posedge clk) begin
    if (m_en && m_wen) begin
      mem[m_addr]    <= m_wdata;
      mem_wr[m_addr] <= 1'b1;
    end
    rd[0] <= mem_wr[m_addr] ? mem[m_addr] : init_val(m_addr);
    for (int i = 1; i < LAT; i++) rd[i] <= rd[i-1];
  end

  assign m_rdata = rd[LAT-1];

  // Behavioural model state.
  typedef struct {
    bit          fetch;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        q [$];
  logic [15:0] shadow [int];
  int          wait_n = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic s_fgnt, s_dgnt, s_frv, s_drv, s_mwen;
  logic [15:0] s_frd, s_drd;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] sh_rd(logic [AW-1:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_val(a);
  endfunction

  task automatic model_check();
    logic fe, ed, ef, ev_f, ev_d;
    logic [15:0] edata;
    exp_t nq [$];
    if (!rst_n) begin
      chk("rst_fgnt", f_gnt, 0);
      chk("rst_dgnt", d_gnt, 0);
      chk("rst_men", m_en, 0);
      chk("rst_mwen", m_wen, 0);
      chk("rst_frv", f_rvalid, 0);
      chk("rst_drv", d_rvalid, 0);
      q.delete();
      wait_n = 0;
      cyc++;
      return;
    end
    fe = f_req & ~flush;
    ed = d_req && !(wait_n >= MAX_WAIT && fe);
    ef = fe && !ed;
    chk("d_gnt", d_gnt, ed);
    chk("f_gnt", f_gnt, ef);
    chk("m_en", m_en, ef | ed);
    chk("m_wen", m_wen, ed & d_wen);
    if (ed) chk("m_addr_d", m_addr, d_addr);
    if (ef) chk("m_addr_f", m_addr, f_addr);
    if (ed && d_wen) chk("m_wdata", m_wdata, d_wdata);
    if (flush) begin
      foreach (q[i]) if (!q[i].fetch) nq.push_back(q[i]);
      q = nq;
    end
    ev_f = 1'b0;
    ev_d = 1'b0;
    edata = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev_f  = q[0].fetch;
      ev_d  = !q[0].fetch;
      edata = q[0].data;
      void'(q.pop_front());
    end
    chk("f_rvalid", f_rvalid, ev_f);
    chk("d_rvalid", d_rvalid, ev_d);
    if (ev_f) chk("f_rdata", f_rdata, edata);
    if (ev_d) chk("d_rdata", d_rdata, edata);
    if (ef) q.push_back('{1'b1, sh_rd(f_addr), cyc + LAT});
    if (ed && !d_wen) q.push_back('{1'b0, sh_rd(d_addr), cyc + LAT});
    if (ed && d_wen) shadow[int'(d_addr)] = d_wdata;
    if (ef || !fe) wait_n = 0;
    else if (wait_n < MAX_WAIT) wait_n++;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    s_fgnt = f_gnt;
    s_dgnt = d_gnt;
    s_frv  = f_rvalid;
    s_drv  = d_rvalid;
    s_frd  = f_rdata;
    s_drd  = d_rdata;
    s_mwen = m_wen;
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    f_req = 1'b0;
    d_req = 1'b0;
    flush = 1'b0;
    repeat (n) step();
  endtask

  logic [5:0] pat;
  logic [3:0] pat4;

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    idle(2);

    // Lone fetch of 0x0010.
    f_req = 1'b1; f_addr = 15'h0010;
    step();
    chk("lit_fetch_gnt", s_fgnt, 1);
    f_req = 1'b0;
    step();
    step();
    chk("lit_fetch_rv", s_frv, 1);
    chk("lit_fetch_rd", s_frd, 16'h5A10);
    idle(2);

    // Fetch vs. load contention: d,d,d,f,d,d.
    f_req = 1'b1; f_addr = 15'h0011;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 15'h0012;
    for (int i = 0; i < 6; i++) begin
      step();
      pat[i] = s_dgnt;
    end
    chk("lit_starve_pat", pat, 6'b110111);
    idle(LAT + 2);

    // Store then fetch of the same word.
    d_req = 1'b1; d_wen = 1'b1; d_addr = 15'h0020; d_wdata = 16'hBEEF;
    step();
    chk("lit_store_wen", s_mwen, 1);
    d_req = 1'b0; d_wen = 1'b0;
    f_req = 1'b1; f_addr = 15'h0020;
    step();
    f_req = 1'b0;
    step();
    chk("lit_store_nodrv", s_drv, 0);
    step();
    chk("lit_st_fetch_rv", s_frv, 1);
    chk("lit_st_fetch_rd", s_frd, 16'hBEEF);
    idle(2);

    // Flush kills an in-flight fetch but not a load.
    f_req = 1'b1; f_addr = 15'h0030;
    step();
    f_req = 1'b0; flush = 1'b1;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 15'h0031;
    step();
    chk("lit_flush_dgnt", s_dgnt, 1);
    flush = 1'b0; d_req = 1'b0;
    step();
    chk("lit_flush_nofrv", s_frv, 0);
    step();
    chk("lit_flush_drv", s_drv, 1);
    chk("lit_flush_drd", s_drd, 16'h5A31);
    idle(2);

    // Alternating fetch/load every cycle.
    for (int i = 0; i < 8; i++) begin
      f_req  = (i % 2) == 0;
      d_req  = (i % 2) == 1;
      d_wen  = 1'b0;
      f_addr = 15'(16'h100 + i);
      d_addr = 15'(16'h200 + i);
      step();
    end
    idle(LAT + 2);

    // Reset with two reads in flight.
    f_req = 1'b1; f_addr = 15'h0040;
    step();
    f_req = 1'b0; d_req = 1'b1; d_wen = 1'b0; d_addr = 15'h0041;
    step();
    f_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("lit_rst_fgnt", f_gnt, 0);
    chk("lit_rst_dgnt", d_gnt, 0);
    chk("lit_rst_men", m_en, 0);
    chk("lit_rst_drv", d_rvalid, 0);
    step();
    step();
    rst_n = 1'b1;
    idle(LAT + 3);
    f_req = 1'b1; f_addr = 15'h0050;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 15'h0051;
    for (int i = 0; i < 4; i++) begin
      step();
      pat4[i] = s_dgnt;
    end
    chk("lit_rst_cnt_pat", pat4, 4'b0111);
    idle(LAT + 2);

    // Randomized traffic with held requests and random flushes.
    for (int n = 0; n < 3000; n++) begin
      if (!f_req || s_fgnt) begin
        f_req  = ($urandom % 4) != 0;
        f_addr = 15'($urandom % 64);
      end
      if (!d_req || s_dgnt) begin
        d_req   = ($urandom % 4) != 0;
        d_wen   = $urandom % 2;
        d_addr  = 15'($urandom % 64);
        d_wdata = 16'($urandom);
      end
      flush = ($urandom % 8) == 0;
      step();
    end
    idle(LAT + 3);
    chk("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
